lvds_7to1_tx_gearbox: RTL and testbench



---
 rtl/lvds_7to1_pkg.sv | 38 +++
 rtl/lvds_tx_gear_lane.sv | 39 +++
 rtl/lvds_7to1_tx_gearbox.sv | 127 ++++++++++++
 tb/tb_lvds_7to1_tx_gearbox.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_7to1_pkg.sv
// Shared constants, state type and phase helpers for the LVDS 7:1 transmit gearbox.
package lvds_7to1_pkg;

  localparam int unsigned PIX_BITS     = 7;
  localparam int unsigned OSER_RATIO   = 4;
  localparam int unsigned GROUP_PHASES = 7;

  localparam logic [2:0] SLOT_PH0   = 3'd0;
  localparam logic [2:0] SLOT_PH1   = 3'd1;
  localparam logic [2:0] SLOT_PH2   = 3'd3;
  localparam logic [2:0] SLOT_PH3   = 3'd5;
  localparam logic [2:0] LAST_PHASE = 3'(GROUP_PHASES - 1);

  localparam logic [PIX_BITS-1:0] DEF_CLK_PATTERN = 7'b1100011;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  function automatic logic is_slot(input logic [2:0] ph);
    return (ph == SLOT_PH0) || (ph == SLOT_PH1) || (ph == SLOT_PH2) || (ph == SLOT_PH3);
  endfunction

  // Residual bits held in the carry register at the start of each phase.
  function automatic logic [2:0] carry_bits(input logic [2:0] ph);
    case (ph)
      3'd1:    return 3'd3;
      3'd2:    return 3'd6;
      3'd3:    return 3'd2;
      3'd4:    return 3'd5;
      3'd5:    return 3'd1;
      3'd6:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lvds_tx_gear_lane.sv
// Single-lane 7->4 packer: pending carry bits go out first, a newly loaded
// pixel (MSB first) is appended behind them, and the lowest 4 bits are emitted.
module lvds_tx_gear_lane
  import lvds_7to1_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_active,
  input  logic                  i_load,
  input  logic [2:0]            i_phase,
  input  logic [PIX_BITS-1:0]   i_pix,
  output logic [OSER_RATIO-1:0] o_word
);

  logic [PIX_BITS-2:0] r_carry;
  logic [PIX_BITS-1:0] w_rev;
  logic [9:0]          w_stream;

  // Load phases hold at most 3 carry bits, so 10 stream bits always suffice.
  always_comb begin
    for (int unsigned j = 0; j < PIX_BITS; j++) w_rev[j] = i_pix[PIX_BITS-1-j];
    w_stream = {4'b0, r_carry};
    if (i_load) w_stream = w_stream | ({3'b0, w_rev} << carry_bits(i_phase));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= '0;
      o_word  <= '0;
    end else if (i_active) begin
      r_carry <= w_stream[9:4];
      o_word  <= w_stream[3:0];
    end else begin
      r_carry <= '0;
      o_word  <= '0;
    end
  end

endmodule

// File: rtl/lvds_7to1_tx_gearbox.sv
// LVDS 7:1 transmit gearbox: 4 pixels per lane packed into 7 OSER4 words plus a
// forwarded-clock lane. Optional PRBS7 test source under `LVDS_TX_PRBS_EN.
module lvds_7to1_tx_gearbox
  import lvds_7to1_pkg::*;
#(
  parameter int unsigned         LANES       = 4,
  parameter logic [PIX_BITS-1:0] CLK_PATTERN = DEF_CLK_PATTERN
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tx_en,
`ifdef LVDS_TX_PRBS_EN
  input  logic                        prbs_sel,
`endif
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [LANES*PIX_BITS-1:0]   s_data,
  output logic [LANES*OSER_RATIO-1:0] tx_data_word,
  output logic [OSER_RATIO-1:0]       tx_clk_word,
  output logic                        frame_start,
  output logic                        underflow,
  output logic [15:0]                 underflow_cnt
);

  state_t                    r_state, w_state_nx;
  logic [2:0]                r_phase, w_phase_nx;
  logic                      r_ready, r_frame, r_uf;
  logic [15:0]               r_ucnt;
  logic                      w_active, w_slot, w_uf;
  logic [LANES*PIX_BITS-1:0] w_fill;

  assign w_active = (r_state == ST_RUN);
  assign w_slot   = w_active && is_slot(r_phase);

  // tx_en is only sampled at the group boundary, so groups are never cut short.
  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    case (r_state)
      ST_IDLE: begin
        w_phase_nx = '0;
        if (tx_en) w_state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (r_phase == LAST_PHASE) begin
          w_phase_nx = '0;
          if (!tx_en) w_state_nx = ST_IDLE;
        end else begin
          w_phase_nx = 3'(r_phase + 3'd1);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_phase_nx = '0;
      end
    endcase
  end

`ifdef LVDS_TX_PRBS_EN
  logic [PIX_BITS-1:0] r_prbs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_prbs <= '1;
    else if (w_slot && prbs_sel) r_prbs <= {r_prbs[5:0], r_prbs[6] ^ r_prbs[5]};
  end

  assign s_ready = r_ready && !prbs_sel;
`else
  assign s_ready = r_ready;
`endif

  always_comb begin
    w_fill = s_valid ? s_data : '0;
    w_uf   = w_slot && !s_valid;
`ifdef LVDS_TX_PRBS_EN
    if (prbs_sel) begin
      w_fill = {LANES{r_prbs}};
      w_uf   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_ready <= 1'b0;
      r_frame <= 1'b0;
      r_uf    <= 1'b0;
      r_ucnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_ready <= (w_state_nx == ST_RUN) && is_slot(w_phase_nx);
      r_frame <= w_active && (r_phase == '0);
      r_uf    <= w_uf;
      if (w_uf && (r_ucnt != '1)) r_ucnt <= r_ucnt + 16'd1;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    lvds_tx_gear_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_active (w_active),
      .i_load   (w_slot),
      .i_phase  (r_phase),
      .i_pix    (w_fill[gi*PIX_BITS +: PIX_BITS]),
      .o_word   (tx_data_word[gi*OSER_RATIO +: OSER_RATIO])
    );
  end

  lvds_tx_gear_lane u_clk_lane (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_active (w_active),
    .i_load   (w_slot),
    .i_phase  (r_phase),
    .i_pix    (CLK_PATTERN),
    .o_word   (tx_clk_word)
  );

  assign frame_start   = r_frame;
  assign underflow     = r_uf;
  assign underflow_cnt = r_ucnt;

endmodule

// File: tb/tb_lvds_7to1_tx_gearbox.sv
// Scoreboard bench: each driven group pushes its 7 expected words, a negedge monitor pops and compares.
module tb_lvds_7to1_tx_gearbox;

  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = LANES * 7;
  localparam int unsigned WW    = LANES * 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_en = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [WW-1:0] tx_data_word;
  logic [3:0]    tx_clk_word;
  logic          frame_start, underflow;
  logic [15:0]   underflow_cnt;
`ifdef LVDS_TX_PRBS_EN
  logic          prbs_sel = 1'b0;
  logic [6:0]    m_prbs = 7'h7F;
`endif

  typedef struct packed {
    logic [WW-1:0] data;
    logic [3:0]    clkw;
    logic          fs;
    logic          uf;
  } exp_t;

  exp_t          q[$];
  exp_t          m_e;
  int unsigned   n_chk = 0;
  int unsigned   n_pass = 0;
  int unsigned   exp_cnt = 0;
  logic [DW-1:0] g_pix [4];
  logic          g_vld [4];
  logic [3:0]    clk_words [7] = '{4'b0011, 4'b1110, 4'b0001, 4'b1111, 4'b1000, 4'b0111, 4'b1100};

  always #5 clk = ~clk;

  lvds_7to1_tx_gearbox #(.LANES(LANES), .CLK_PATTERN(7'b1100011)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_en         (tx_en),
`ifdef LVDS_TX_PRBS_EN
    .prbs_sel      (prbs_sel),
`endif
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .tx_data_word  (tx_data_word),
    .tx_clk_word   (tx_clk_word),
    .frame_start   (frame_start),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int slot_of(input int p);
    case (p)
      0:       return 0;
      1:       return 1;
      3:       return 2;
      5:       return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic build_group(input int unsigned mode);
    for (int k = 0; k < 4; k++) begin
      g_vld[k] = 1'b1;
      g_pix[k] = '0;
    end
    case (mode)
      0: for (int k = 0; k < 4; k++) g_vld[k] = 1'b0;
      1: for (int k = 0; k < 4; k++) g_pix[k] = {LANES{7'h7F}};
      2: g_pix[0][6:0] = 7'h40;
      3: g_pix[3][6:0] = 7'h01;
      4: begin
        for (int k = 0; k < 4; k++) g_pix[k] = rnd_data();
        g_vld[2] = 1'b0;
      end
      5: for (int k = 0; k < 4; k++) begin
        g_pix[k] = rnd_data();
        g_vld[k] = ($urandom_range(0, 3) != 0);
      end
`ifdef LVDS_TX_PRBS_EN
      6: for (int k = 0; k < 4; k++) begin
        g_pix[k] = {LANES{m_prbs}};
        m_prbs = {m_prbs[5:0], m_prbs[6] ^ m_prbs[5]};
      end
`endif
      default: ;
    endcase
  endtask

  // Each lane is a 28-bit stream: index 7k+j carries pixel k bit 6-j; word p is indices 4p..4p+3.
  task automatic push_group();
    exp_t e;
    for (int p = 0; p < 7; p++) begin
      e.data = '0;
      for (int i = 0; i < int'(LANES); i++)
        for (int b = 0; b < 4; b++) begin
          int idx = 4 * p + b;
          int k = idx / 7;
          int j = idx % 7;
          e.data[4*i+b] = g_vld[k] ? g_pix[k][7*i+6-j] : 1'b0;
        end
      e.clkw = clk_words[p];
      e.fs   = (p == 0);
      e.uf   = (slot_of(p) >= 0) ? !g_vld[slot_of(p)] : 1'b0;
      q.push_back(e);
    end
  endtask

  // Entered #1 after the edge that starts phase 0; leaves #1 after the edge ending the last phase driven.
  task automatic drive_group(input int unsigned mode, input int drop_at, input int reassert_at, input int nph);
    int s;
    build_group(mode);
    push_group();
    for (int p = 0; p < nph; p++) begin
      s = slot_of(p);
      if (s >= 0 && mode != 6) begin
        s_valid = g_vld[s];
        s_data  = g_pix[s];
      end else begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = rnd_data();
      end
      chk("s_ready", 64'(s_ready), 64'((s >= 0) && (mode != 6)));
      if (p == drop_at) tx_en = 1'b0;
      if (p == reassert_at) tx_en = 1'b1;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (tx_clk_word != 4'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_word", 64'(tx_clk_word), 64'(0));
      end else begin
        m_e = q.pop_front();
        if (m_e.uf && exp_cnt < 16'hFFFF) exp_cnt++;
        chk("tx_data_word", 64'(tx_data_word), 64'(m_e.data));
        chk("tx_clk_word", 64'(tx_clk_word), 64'(m_e.clkw));
        chk("frame_start", 64'(frame_start), 64'(m_e.fs));
        chk("underflow", 64'(underflow), 64'(m_e.uf));
        chk("underflow_cnt", 64'(underflow_cnt), 64'(exp_cnt));
      end
    end else begin
      chk("idle_data", 64'(tx_data_word), 64'(0));
      chk("idle_flags", 64'({frame_start, underflow}), 64'(0));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 64'(tx_data_word), 64'(0));
    chk("reset_clk", 64'(tx_clk_word), 64'(0));
    chk("reset_cnt", 64'(underflow_cnt), 64'(0));
    chk("reset_ready", 64'(s_ready), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", 64'(s_ready), 64'(0));
    tx_en = 1'b1;
    @(posedge clk);
    #1;
    drive_group(0, -1, -1, 7);
    drive_group(0, -1, -1, 7);
    drive_group(1, -1, -1, 7);
    drive_group(2, -1, -1, 7);
    drive_group(3, -1, -1, 7);
    drive_group(4, -1, -1, 7);
    for (int g = 0; g < 6; g++) drive_group(5, -1, -1, 7);
    drive_group(5, 2, -1, 7);
    repeat (3) @(posedge clk);
    #1;
    chk("drained_ready", 64'(s_ready), 64'(0));
    tx_en = 1'b1;
    @(posedge clk);
    #1;
    drive_group(5, 2, 4, 7);
    drive_group(1, -1, -1, 7);
`ifdef LVDS_TX_PRBS_EN
    prbs_sel = 1'b1;
    drive_group(6, -1, -1, 7);
    drive_group(6, -1, -1, 7);
    prbs_sel = 1'b0;
`endif
    drive_group(5, 3, -1, 7);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'(0));
    tx_en = 1'b1;
    @(posedge clk);
    #1;
    drive_group(4, -1, -1, 3);
    rst_n = 1'b0;
    q.delete();
    exp_cnt = 0;
    tx_en = 1'b0;
    #1;
    chk("async_rst_data", 64'(tx_data_word), 64'(0));
    chk("async_rst_clk", 64'(tx_clk_word), 64'(0));
    chk("async_rst_cnt", 64'(underflow_cnt), 64'(0));
    chk("async_rst_ready", 64'(s_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle", 64'(tx_clk_word), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
